// File: rtl/mau_pkg.sv
// Shared MAU definitions: opcode values, instruction field positions, store-unit state encoding.
// No logic; imported by the store unit.
package mau_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam int INSTR_SEL_LSB = 6;
    localparam int INSTR_OP_LSB  = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_STREAM       = 2'd1,
        ST_DRAIN        = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } store_state_t;

endpackage

// File: rtl/mau_skid_buffer.sv
// Two-entry output stage (output register + skid register) with fall-through when empty.
// Latency: 0 cycles when empty (input shown directly), otherwise registered.
// Backpressure: holds out_dat stable while out_vld && !out_rdy; caller must keep occ+in_vld <= 2.
module mau_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy,
    output logic [1:0]   occ
);

    logic         head_full;
    logic         skid_full;
    logic [W-1:0] head_dat;
    logic [W-1:0] skid_dat;
    logic         hs;

    assign out_vld = head_full | in_vld;
    assign out_dat = (head_full || !in_vld) ? head_dat : in_dat;
    assign hs      = out_vld & out_rdy;
    assign occ     = {1'b0, head_full} + {1'b0, skid_full};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_full <= 1'b0;
            skid_full <= 1'b0;
            head_dat  <= '0;
            skid_dat  <= '0;
        end else if (head_full) begin
            if (hs) begin
                // skid entry always advances ahead of newly returned data
                if (skid_full) begin
                    head_dat  <= skid_dat;
                    skid_full <= in_vld;
                    if (in_vld) skid_dat <= in_dat;
                end else begin
                    head_full <= in_vld;
                    if (in_vld) head_dat <= in_dat;
                end
            end else if (in_vld) begin
                skid_full <= 1'b1;
                skid_dat  <= in_dat;
            end
        end else if (in_vld && !hs) begin
            head_full <= 1'b1;
            head_dat  <= in_dat;
        end
    end

endmodule

// File: rtl/mau_store_unit.sv
// Streams all MATRIX_DIM^2 bytes of one BRAM to the host on an edge-qualified STORE.
// Latency: STORE sampled -> read issued next cycle -> byte on data_out the cycle after.
// Backpressure: credit of 2 (in-flight read + buffered bytes) makes host_ready stalls lossless.
module mau_store_unit #(
    parameter int MATRIX_DIM = 8,
    parameter int ADDR_W     = $clog2(MATRIX_DIM * MATRIX_DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        host_instruction,
    input  logic              host_ready,
    output logic [1:0]        bram_sel,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_rd_data,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              busy_flag
);
    import mau_pkg::*;

    localparam int                DEPTH     = MATRIX_DIM * MATRIX_DIM;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    store_state_t      state;
    store_state_t      state_nxt;
    logic              armed;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   hs_cnt;
    logic              inflight;

    logic [1:0] opcode;
    logic       is_store;
    logic       start;
    logic       hs;
    logic       out_vld;
    logic [1:0] occ;
    logic       credit_ok;
    logic       last_issue;
    logic       last_hs;
    logic [3:0] unused_instr_bits;

    assign opcode            = host_instruction[INSTR_OP_LSB +: 2];
    assign unused_instr_bits = {host_instruction[5:4], host_instruction[1:0]};
    assign is_store          = (opcode == OP_STORE);
    assign start             = (state == ST_IDLE) && is_store && armed;
    assign hs                = out_vld & host_ready;
    // occupancy left after this cycle's handshake must stay below 2 to issue
    assign credit_ok  = ({2'b00, inflight} + {1'b0, occ}) < (3'd2 + {2'b00, hs});
    assign last_issue = bram_rd_en && (addr_q == LAST_ADDR);
    assign last_hs    = hs && (hs_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:         if (start) state_nxt = ST_STREAM;
            ST_STREAM:       if (last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN:        if (last_hs) state_nxt = is_store ? ST_WAIT_RELEASE : ST_IDLE;
            ST_WAIT_RELEASE: if (!is_store) state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_flag  = (state == ST_STREAM) || (state == ST_DRAIN);
        bram_rd_en = (state == ST_STREAM) && credit_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b1;
            sel_q    <= 2'd0;
            addr_q   <= '0;
            hs_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= bram_rd_en;
            if (start) begin
                armed  <= 1'b0;
                sel_q  <= host_instruction[INSTR_SEL_LSB +: 2];
                addr_q <= '0;
                hs_cnt <= '0;
            end else begin
                if (!is_store && (state == ST_IDLE || state == ST_WAIT_RELEASE || last_hs))
                    armed <= 1'b1;
                if (bram_rd_en && addr_q != LAST_ADDR)
                    addr_q <= addr_q + 1'b1;
                if (hs)
                    hs_cnt <= hs_cnt + 1'b1;
            end
        end
    end

    assign bram_sel   = sel_q;
    assign bram_addr  = addr_q;
    assign data_valid = out_vld;

    mau_skid_buffer #(.W(8)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (inflight),
        .in_dat  (bram_rd_data),
        .out_vld (out_vld),
        .out_dat (data_out),
        .out_rdy (host_ready),
        .occ     (occ)
    );

endmodule

// File: doc/mau_store_unit.md
Name: mau_store_unit

Overview:
- Host-side readout engine for the Matrix Algebra Unit: the reverse direction of the host LOAD path.
- On a STORE instruction it streams all MATRIX_DIM*MATRIX_DIM bytes of one selected BRAM to the host on data_out, in ascending address order.
- Sits between the MAU instruction decode and the four BRAM read ports. Raises busy_flag for the whole transfer and honours host backpressure.

Parameters:
- MATRIX_DIM, 8, matrix side length; one transfer moves MATRIX_DIM*MATRIX_DIM bytes (64 at default).
- ADDR_W, $clog2(MATRIX_DIM*MATRIX_DIM), BRAM byte-address width (6 at default).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- host_instruction  in  8  [7:6] BRAM select, [3:2] opcode (00 NOP, 01 LOAD, 10 STORE), other bits ignored.
- host_ready  in  1  host accepts data_out this cycle.
- bram_sel  out  2  BRAM being read; muxes the four read ports.
- bram_rd_en  out  1  read strobe to the selected BRAM.
- bram_addr  out  ADDR_W  byte address for bram_rd_en.
- bram_rd_data  in  8  read data, valid exactly 1 cycle after bram_rd_en.
- data_out  out  8  byte to host.
- data_valid  out  1  data_out holds a byte; the byte transfers when data_valid && host_ready.
- busy_flag  out  1  transfer in progress.

Behaviour:
- Reset (rst=0, async): state IDLE, busy_flag=0, data_valid=0, data_out=8'h00, bram_rd_en=0, bram_addr=0, bram_sel=0, armed=1. All in-flight reads and buffered bytes are discarded. Reset mid-transfer aborts with no further data_valid.
- States: IDLE, STREAM, DRAIN, WAIT_RELEASE.
- IDLE:
  - If opcode==10 and armed=1: latch bram_sel from [7:6], clear addr/count, clear armed, go to STREAM. busy_flag=1 from the next cycle.
  - Any opcode other than 10 sets armed=1. Opcodes 00 and 01 never start this unit.
- Start is edge-qualified: a STORE held constant after completion does not retrigger. The host must present a non-STORE opcode for at least one cycle before another STORE.
- STREAM:
  - Issue reads addr 0 .. N*N-1, at most one per cycle.
  - Read issue rule: bram_rd_en=1 only if (in-flight reads + output register + skid entry occupancy) < 2 after this cycle's host handshake. This gives lossless backpressure with one output register plus one skid register.
  - Returned bytes go to the output register if it is empty or being consumed; otherwise they go to the skid register. The skid entry moves to the output register first.
  - After the last address is issued, go to DRAIN.
- DRAIN: no new reads. When the final byte is handshaken (data_valid && host_ready), busy_flag=0 next cycle; go to WAIT_RELEASE, or to IDLE if the opcode is already non-STORE.
- WAIT_RELEASE: busy_flag=0. A non-STORE opcode sets armed=1 and goes to IDLE.
- Instruction changes during STREAM/DRAIN are ignored; bram_sel stays fixed for the transfer.
- Latency with host_ready=1 throughout:
  - Cycle 0: STORE sampled.
  - Cycle 1: busy_flag=1, bram_rd_en=1, addr 0.
  - Cycle 2: data_valid=1, byte 0.
  - Then one byte per cycle.
  - busy_flag deasserts the cycle after byte N*N-1 is taken. Total busy = N*N+1 cycles (65 at default).
- Ordering: bytes are delivered strictly in address order, no loss or duplication, under any host_ready pattern.
- data_out is held stable while data_valid && !host_ready.
- Handshake counter is ADDR_W+1 bits; it terminates at exactly N*N with no wrap. bram_addr never exceeds N*N-1.

Decomposition:
- Shared package mau_pkg:
  - Opcode constants OP_NOP=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10.
  - Instruction field positions: BRAM select [7:6], opcode [3:2].
  - State encoding typedef for this unit.
- Natural sub-module: mau_skid_buffer, an 8-bit, 2-entry output register plus skid register with valid/ready. The FSM and read-issue credit logic stay in mau_store_unit.

Test Plan:
- Reset, then host_instruction=8'h00 for 20 cycles -> busy_flag=0, data_valid=0, bram_rd_en=0.
- BRAM 2 preloaded with byte i = i, STORE 8'b10_00_10_00, host_ready=1 -> busy rises 1 cycle later; bytes 00..3F on 64 consecutive cycles; busy high exactly 65 cycles; bram_sel=2 throughout.
- STORE to BRAM 1 with host_ready toggling 1,0,0,1 repeating -> 64 bytes 00..3F in order, none dropped or duplicated; data_out stable while stalled; ≤2 reads outstanding.
- STORE held constant after completion for 100 cycles -> no second transfer. Then NOP for 1 cycle, then STORE -> second transfer starts.
- rst driven low asynchronously after 20 bytes of a transfer -> busy_flag, data_valid, bram_rd_en go 0 immediately. After release with NOP, a STORE restarts cleanly at byte 0.
- Instruction changed to LOAD on BRAM 0 mid-transfer -> ignored; transfer completes from the original BRAM.
